// File: rtl/aes128_encrypt_iterative.sv
// ---------------------------------------------------------------------------
// aes128_encrypt_iterative
//
// This is an iterative AES-128 encryption core (FIPS-197 Cipher). The initial
// AddRoundKey is applied when a block is accepted. Ten forward rounds then run
// at one round per clock. Round keys are expanded on the fly from the previous
// round key, so no key schedule is stored.
//
// Byte ordering: byte 0 is bits [127:120]. The state is column-major, so
// state[row][col] is byte (row + 4*col).
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous, active-low reset
//   in_valid    plaintext/key presented
//   in_ready    core can accept a block (high only in IDLE)
//   plaintext   128-bit input block
//   key         128-bit cipher key
//   out_valid   ciphertext available
//   out_ready   consumer accepts ciphertext
//   ciphertext  128-bit result block (holds last result until next DONE)
//   dbg_state   current FSM state (IDLE=0, ROUND=1, DONE=2)
//
// Handshakes: a transfer happens on a rising edge where valid && ready. Once
// out_valid is raised, it stays high and ciphertext stays stable until that
// transfer. in_ready is high only in IDLE, and in_valid is ignored elsewhere.
// The output handshake edge returns the core to IDLE. Because of that, a new
// block can be accepted no earlier than the following edge.
// ---------------------------------------------------------------------------
module aes128_encrypt_iterative (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Forward S-box. Entry x sits at bits [2047-8x -: 8].
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      int idx;
      idx = 255 - int'(x);
      return SBOX_TBL[idx*8 +: 8];
   endfunction

   // GF(2^8) doubling, reduced by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) begin
         o[i*8 +: 8] = sbox(s[i*8 +: 8]);
      end
      return o;
   endfunction

   // Row r is rotated left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // Next AES-128 round key. Word 0 takes SubWord(RotWord(w3)) ^ Rcon, and
   // words 1..3 chain-XOR off the freshly produced word before them.
   function automatic logic [127:0] next_key(input logic [127:0] rk,
                                             input logic [7:0]   rc);
      logic [31:0] w0, w1, w2, w3, t;
      w0 = rk[127:96];
      w1 = rk[95:64];
      w2 = rk[63:32];
      w3 = rk[31:0];
      t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   state_t       state_q, state_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] rk_q, rk_d;
   logic [3:0]   round_q, round_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [127:0] ct_q, ct_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;

   logic [127:0] sr_w, mc_w, nk_w, rnd_w;

   always_comb begin
      sr_w  = shift_rows(sub_bytes(blk_q));
      mc_w  = mix_columns(sr_w);
      nk_w  = next_key(rk_q, rcon_q);
      // The final round has no MixColumns.
      rnd_w = ((round_q == 4'd10) ? sr_w : mc_w) ^ nk_w;
   end

   always_comb begin
      state_d     = state_q;
      blk_d       = blk_q;
      rk_d        = rk_q;
      round_d     = round_q;
      rcon_d      = rcon_q;
      ct_d        = ct_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               state_d    = S_ROUND;
               blk_d      = plaintext ^ key;
               rk_d       = key;
               round_d    = 4'd1;
               rcon_d     = 8'h01;
               in_ready_d = 1'b0;
            end
         end
         S_ROUND: begin
            blk_d   = rnd_w;
            rk_d    = nk_w;
            rcon_d  = xtime(rcon_q);
            round_d = round_q + 4'd1;
            if (round_q == 4'd10) begin
               state_d     = S_DONE;
               ct_d        = rnd_w;
               out_valid_d = 1'b1;
            end
         end
         S_DONE: begin
            if (out_valid_q && out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         blk_q       <= '0;
         rk_q        <= '0;
         round_q     <= 4'd0;
         rcon_q      <= 8'h01;
         ct_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         blk_q       <= blk_d;
         rk_q        <= rk_d;
         round_q     <= round_d;
         rcon_q      <= rcon_d;
         ct_q        <= ct_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign ciphertext = ct_q;
   assign dbg_state  = state_q;

endmodule
